// File: rtl/delay_line_ctrl_if.sv
// Controller <-> FIFO bus. The master (delay_line_ctrl) owns data_in, wr_en
// and rd_en. The slave (the FIFO) returns data_out, empty and full.
//   fifo_data_in   master->slave  write data
//   fifo_wr_en     master->slave  write enable
//   fifo_rd_en     master->slave  read enable
//   fifo_data_out  slave->master  read data, valid the cycle after fifo_rd_en
//   fifo_empty     slave->master  FIFO empty
//   fifo_full      slave->master  FIFO full
interface delay_line_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_wr_en;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_empty;
    logic             fifo_full;

    modport master (
        output fifo_data_in, fifo_wr_en, fifo_rd_en,
        input  fifo_data_out, fifo_empty, fifo_full
    );

    modport slave (
        input  fifo_data_in, fifo_wr_en, fifo_rd_en,
        output fifo_data_out, fifo_empty, fifo_full
    );
endinterface

// File: rtl/delay_line_ctrl.sv
// Programmable sample delay built around one external synchronous FIFO.
// The controller tracks FIFO occupancy itself. It pads the output with zeros
// while the line fills, and it discards the oldest samples when the delay
// shrinks.
//   clk, n_reset        clock, synchronous active-low reset (shared with FIFO)
//   delay               requested delay in samples (clamped to 1..DEPTH-1)
//   sample_in(_valid)   input sample and its one-cycle strobe
//   sample_out(_valid)  delayed sample, valid exactly one cycle after strobe
//   fifo                master side of the FIFO bus
//   level               tracked FIFO occupancy
//   state               0 FILL, 1 RUN, 2 TRIM
//   error               sticky occupancy-mismatch flag
module delay_line_ctrl #(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned DEPTH     = 10,
    localparam int unsigned CTR_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic [CTR_WIDTH-1:0]    delay,
    input  logic [WIDTH-1:0]        sample_in,
    input  logic                    sample_in_valid,
    output logic [WIDTH-1:0]        sample_out,
    output logic                    sample_out_valid,
    delay_line_ctrl_if.master       fifo,
    output logic [CTR_WIDTH-1:0]    level,
    output logic [1:0]              state,
    output logic                    error
);

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRIM = 2'd2
    } state_t;

    // A full FIFO drops writes even on a simultaneous read, so cap one short of DEPTH.
    localparam logic [CTR_WIDTH-1:0] MAX_DELAY = CTR_WIDTH'(DEPTH - 1);
    localparam logic [CTR_WIDTH-1:0] FULL_LVL  = CTR_WIDTH'(DEPTH);

    state_t               state_q, state_nxt;
    logic [CTR_WIDTH-1:0] level_q, level_nxt;
    logic [CTR_WIDTH-1:0] d_eff;
    logic                 wr_c, rd_c;
    logic                 valid_q;
    logic                 rd_flag_q;
    logic [WIDTH-1:0]     hold_q;
    logic                 error_q;

    // Effective delay clamp.
    always_comb begin
        d_eff = delay;
        if (delay == '0) begin
            d_eff = CTR_WIDTH'(1);
        end else if (delay > MAX_DELAY) begin
            d_eff = MAX_DELAY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state from post-update occupancy against the current effective delay.
    always_comb begin
        state_nxt = state_q;
        if (level_nxt < d_eff) begin
            state_nxt = ST_FILL;
        end else if (level_nxt == d_eff) begin
            state_nxt = ST_RUN;
        end else begin
            state_nxt = ST_TRIM;
        end
    end

    // FIFO strobes. A strobe in TRIM behaves as in RUN and takes the place of a trim step.
    always_comb begin
        wr_c = 1'b0;
        rd_c = 1'b0;
        if (n_reset) begin
            case (state_q)
                ST_FILL: begin
                    wr_c = sample_in_valid;
                end
                ST_RUN, ST_TRIM: begin
                    if (sample_in_valid) begin
                        wr_c = 1'b1;
                        rd_c = 1'b1;
                    end else if (state_q == ST_TRIM && level_q > d_eff) begin
                        rd_c = 1'b1;
                    end
                end
                default: begin
                    wr_c = 1'b0;
                    rd_c = 1'b0;
                end
            endcase
        end
        wr_c = wr_c & ~fifo.fifo_full;
        rd_c = rd_c & ~fifo.fifo_empty;
    end

    // Occupancy update.
    always_comb begin
        level_nxt = level_q;
        case ({wr_c, rd_c})
            2'b10:   level_nxt = level_q + CTR_WIDTH'(1);
            2'b01:   level_nxt = level_q - CTR_WIDTH'(1);
            default: level_nxt = level_q;
        endcase
    end

    // Occupancy, output bookkeeping and the sticky error flag.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            level_q   <= '0;
            valid_q   <= 1'b0;
            rd_flag_q <= 1'b0;
            hold_q    <= '0;
            error_q   <= 1'b0;
        end else begin
            level_q   <= level_nxt;
            valid_q   <= sample_in_valid;
            rd_flag_q <= rd_c;
            hold_q    <= sample_out;
            if ((fifo.fifo_empty && level_q != '0) ||
                (fifo.fifo_full && level_q != FULL_LVL)) begin
                error_q <= 1'b1;
            end
        end
    end

    // FIFO read data arrives the cycle after the strobe; a fill strobe yields zero.
    // Between strobes the last output is held.
    always_comb begin
        sample_out = hold_q;
        if (valid_q) begin
            sample_out = rd_flag_q ? fifo.fifo_data_out : '0;
        end
    end

    assign fifo.fifo_data_in = sample_in;
    assign fifo.fifo_wr_en   = wr_c;
    assign fifo.fifo_rd_en   = rd_c;
    assign sample_out_valid  = valid_q;
    assign level             = level_q;
    assign state             = state_q;
    assign error             = error_q;

endmodule

// File: tb/tb_delay_line_ctrl.sv
module tb_delay_line_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 10;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             n_reset;
    logic [CW-1:0]    delay;
    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic [WIDTH-1:0] sample_out;
    logic             sample_out_valid;
    logic [CW-1:0]    level;
    logic [1:0]       state;
    logic             error;

    int checks = 0;
    int fails  = 0;

    delay_line_ctrl_if #(.WIDTH(WIDTH)) ff_if ();

    delay_line_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .n_reset          (n_reset),
        .delay            (delay),
        .sample_in        (sample_in),
        .sample_in_valid  (sample_in_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid),
        .fifo             (ff_if.master),
        .level            (level),
        .state            (state),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Reference synchronous FIFO: drops writes when full, registered read data.
    logic [WIDTH-1:0] mem [DEPTH];
    int               wp, rp, cnt;
    logic             do_w, do_r;
    logic [WIDTH-1:0] dout;

    assign ff_if.fifo_data_out = dout;
    assign ff_if.fifo_empty    = (cnt == 0);
    assign ff_if.fifo_full     = (cnt == DEPTH);

    always @(posedge clk) begin
        do_w = ff_if.fifo_wr_en && (cnt != DEPTH);
        do_r = ff_if.fifo_rd_en && (cnt != 0);
        if (!n_reset) begin
            wp   <= 0;
            rp   <= 0;
            cnt  <= 0;
            dout <= '0;
        end else begin
            if (do_r) begin
                dout <= mem[rp];
                rp   <= (rp + 1) % DEPTH;
            end
            if (do_w) begin
                mem[wp] <= ff_if.fifo_data_in;
                wp      <= (wp + 1) % DEPTH;
            end
            cnt <= cnt + (do_w ? 1 : 0) - (do_r ? 1 : 0);
        end
    end

    // Guard and full-flag monitors.
    logic full_seen = 1'b0;
    logic guard_bad = 1'b0;
    always @(posedge clk) begin
        if (n_reset) begin
            if (ff_if.fifo_full) full_seen <= 1'b1;
            if ((ff_if.fifo_wr_en && ff_if.fifo_full) ||
                (ff_if.fifo_rd_en && ff_if.fifo_empty)) guard_bad <= 1'b1;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic strobe(input int d, input int exp_out, input string tag);
        @(negedge clk);
        sample_in       = WIDTH'(d);
        sample_in_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_in_valid = 1'b0;
        chk({tag, "_valid"}, int'(sample_out_valid), 1);
        chk({tag, "_out"}, int'(sample_out), exp_out);
    endtask

    task automatic idle(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            sample_in_valid = 1'b0;
            @(posedge clk);
            #1;
            chk({tag, "_novalid"}, int'(sample_out_valid), 0);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        n_reset         = 1'b0;
        sample_in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_level"}, int'(level), 0);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_out"}, int'(sample_out), 0);
        chk({tag, "_valid"}, int'(sample_out_valid), 0);
        chk({tag, "_err"}, int'(error), 0);
        chk({tag, "_wr"}, int'(ff_if.fifo_wr_en), 0);
        chk({tag, "_rd"}, int'(ff_if.fifo_rd_en), 0);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_reset         = 1'b0;
        delay           = CW'(3);
        sample_in       = '0;
        sample_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        do_reset("rst0");

        // Fill to delay 3, then run.
        idle(1, "t1");
        strobe(1, 0, "t1_s1"); idle(1, "t1");
        strobe(2, 0, "t1_s2"); idle(1, "t1");
        strobe(3, 0, "t1_s3"); idle(1, "t1");
        strobe(4, 1, "t1_s4"); idle(1, "t1");
        strobe(5, 2, "t1_s5"); idle(1, "t1");
        strobe(6, 3, "t1_s6"); idle(1, "t1");
        chk("t1_level", int'(level), 3);
        chk("t1_state", int'(state), 1);

        // Shrink to 1: two discarded reads, output held.
        @(negedge clk); delay = CW'(1);
        idle(3, "t2");
        chk("t2_level", int'(level), 1);
        chk("t2_state", int'(state), 1);
        chk("t2_held", int'(sample_out), 3);
        strobe(7, 6, "t2_s7");

        // Grow to 4: three zero fills, then data.
        @(negedge clk); delay = CW'(4);
        idle(1, "t3");
        chk("t3_state_fill", int'(state), 0);
        strobe(8, 0, "t3_s8");
        strobe(9, 0, "t3_s9");
        strobe(10, 0, "t3_s10");
        chk("t3_state_run", int'(state), 1);
        strobe(11, 7, "t3_s11");
        chk("t3_level", int'(level), 4);

        // delay 0 acts as 1.
        @(negedge clk); delay = CW'(0);
        idle(6, "t4");
        chk("t4_level", int'(level), 1);
        chk("t4_state", int'(state), 1);
        strobe(12, 11, "t4_s12");

        // delay DEPTH acts as DEPTH-1.
        do_reset("rst1");
        delay = CW'(10);
        idle(1, "t5");
        for (int i = 1; i <= 9; i++) strobe(i, 0, "t5_fill");
        chk("t5_level", int'(level), 9);
        chk("t5_state", int'(state), 1);
        strobe(10, 1, "t5_s10");
        strobe(11, 2, "t5_s11");
        strobe(12, 3, "t5_s12");
        chk("t5_level_run", int'(level), 9);

        // Back-to-back strobes at delay 2.
        do_reset("rst2");
        delay = CW'(2);
        idle(1, "t6");
        strobe(1, 0, "t6_b1");
        strobe(2, 0, "t6_b2");
        for (int i = 3; i <= 8; i++) strobe(i, i - 2, "t6_b");
        chk("t6_level", int'(level), 2);

        // Reset mid-run at delay 3.
        do_reset("rst3");
        delay = CW'(3);
        idle(1, "t7");
        strobe(1, 0, "t7_p1");
        strobe(2, 0, "t7_p2");
        strobe(3, 0, "t7_p3");
        strobe(4, 1, "t7_p4");
        chk("t7_state_run", int'(state), 1);
        do_reset("rst_mid");
        idle(1, "t7");
        strobe(20, 0, "t7_s20");
        strobe(21, 0, "t7_s21");
        strobe(22, 0, "t7_s22");
        strobe(23, 20, "t7_s23");
        chk("t7_level", int'(level), 3);

        chk("full_never", int'(full_seen), 0);
        chk("guards", int'(guard_bad), 0);
        chk("error_final", int'(error), 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequences a single synchronous FIFO instance (WIDTH/DEPTH matched) so that it implements a programmable sample delay of D samples.
- Sits between the sample source and the sample sink, and owns the FIFO's wr_en and rd_en.
- Tracks FIFO occupancy itself.
- Handles run-time changes of D: fills with zero output when D grows, and discards the oldest samples when D shrinks.

Parameters:
- WIDTH, 8, sample width in bits; must equal the FIFO's WIDTH.
- DEPTH, 10, FIFO depth; must equal the FIFO's DEPTH.
- CTR_WIDTH, $clog2(DEPTH+1), width of the delay and level fields (localparam).

Ports:
- clk  in  1  clock
- n_reset  in  1  reset, synchronous, active-low; the FIFO shares this same reset
- delay  in  CTR_WIDTH  requested delay in samples
- sample_in  in  WIDTH  input sample
- sample_in_valid  in  1  sample strobe, one cycle per sample
- sample_out  out  WIDTH  delayed sample (registered)
- sample_out_valid  out  1  one-cycle pulse per output sample
- fifo_data_in  out  WIDTH  to FIFO data_in; equals sample_in combinationally
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_rd_en  out  1  to FIFO rd_en
- fifo_data_out  in  WIDTH  from FIFO data_out; valid the cycle after fifo_rd_en
- fifo_empty  in  1  from FIFO
- fifo_full  in  1  from FIFO
- level  out  CTR_WIDTH  tracked FIFO occupancy
- state  out  2  current state: 0 FILL, 1 RUN, 2 TRIM
- error  out  1  sticky occupancy-mismatch flag

Behaviour:
- Delay clamp:
  - D_eff = 1 if delay == 0.
  - D_eff = DEPTH-1 if delay > DEPTH-1.
  - Otherwise D_eff = delay.
  - Reason for the DEPTH-1 cap: the FIFO drops a write while full even when a read occurs in the same cycle.
  - delay is sampled every cycle.
- Reset: all of the following are 0: level, sample_out, sample_out_valid, fifo_wr_en, fifo_rd_en, error. state = FILL.
- level: +1 on a write-only cycle, -1 on a read-only cycle, unchanged on read+write or idle cycles.
- FILL (level < D_eff):
  - Strobe: write only; the following cycle outputs sample_out = 0 with valid = 1.
  - Moves to RUN when the post-update level == D_eff.
- RUN (level == D_eff):
  - Strobe: read and write in the same cycle.
  - The next cycle gives sample_out = fifo_data_out and valid = 1.
- Leaving RUN: if D_eff > level, go to FILL; if D_eff < level, go to TRIM. These are evaluated every cycle.
- TRIM (level > D_eff):
  - Each non-strobe cycle issues a read only, with the data discarded: no sample_out_valid and sample_out is unchanged.
  - A strobe in TRIM behaves as in RUN (read+write, output valid) and performs no trim step.
  - Moves to RUN when level == D_eff; moves to FILL if D_eff rises above level.
  - With strobes on every cycle, trimming stalls. This is accepted behaviour.
- Latency: sample_out_valid is asserted exactly 1 cycle after every sample_in_valid, with no exceptions.
- Output zero/data select is driven by a registered flag recording whether the strobe cycle issued a read.
- Guards:
  - fifo_wr_en is never asserted while fifo_full.
  - fifo_rd_en is never asserted while fifo_empty.
- error is set and held until reset when either of these is seen:
  - fifo_empty while level != 0
  - fifo_full while level != DEPTH
- Reset mid-operation: level returns to 0, the FIFO clears with it, and the next D_eff outputs are zero.

Test Plan:
- Reset, delay=3, strobes 1..6 every 2 cycles -> outputs 0,0,0,1,2,3, each 1 cycle after its strobe; level=3, state=RUN.
- From the previous state (FIFO holds 4,5,6), set delay=1 and leave 3 idle cycles -> two read-only cycles with no valid pulse, level=1, state=RUN; strobe 7 -> output 6.
- Then delay=4, strobes 8,9,10,11 -> outputs 0,0,0,7; state FILL for 3 strobes, then RUN, level=4.
- delay=0 behaves as delay=1; delay=10 (DEPTH) behaves as 9: after 9 zero outputs, output = input from 9 strobes earlier; fifo_full never asserted and error=0.
- delay=2, strobe every cycle with inputs 1..8 -> sample_out_valid continuous, outputs 0,0,1,2,3,4,5,6.
- Reset asserted for 1 cycle mid-RUN with delay=3 -> the next cycle shows all outputs 0 and state FILL; next strobes 20,21,22,23 -> outputs 0,0,0,20.
